// File: rtl/pixel_classifier.sv
// Classifies an RGB pixel stream into 2-bit colour classes and frames exactly
// image_size pixels per frame onto the sram_controller write port.
module pixel_classifier #(
   parameter int COLOR_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [22:0]            image_size,
   input  logic [COLOR_WIDTH-1:0] red_thr,
   input  logic [COLOR_WIDTH-1:0] green_thr,
   input  logic [COLOR_WIDTH-1:0] blue_thr,
   input  logic [COLOR_WIDTH-1:0] diff_thr,
   input  logic                   in_sof,
   input  logic                   in_valid,
   input  logic [COLOR_WIDTH-1:0] in_red,
   input  logic [COLOR_WIDTH-1:0] in_green,
   input  logic [COLOR_WIDTH-1:0] in_blue,
   output logic                   write_image_en,
   output logic                   write_image,
   output logic [1:0]             write_image_data,
   input  logic                   write_image_done,
   input  logic                   clear_status,
   output logic                   short_frame,
   output logic                   busy,
   output logic [15:0]            frames_done
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SOF,
      STREAM,
      PAD,
      FLUSH
   } state_t;

   localparam int EW = COLOR_WIDTH + 1;

   state_t state, next_state;

   logic [22:0]            count;
   logic                   accept, inject, start, set_short, frame_end;
   logic                   last_pixel, pipe_empty;

   logic                   cap_valid, cap_pad;
   logic [COLOR_WIDTH-1:0] cap_red, cap_green, cap_blue;
   logic                   s1_valid;
   logic [2:0]             s1_hit;   // {blue, green, red}

   logic [EW-1:0]          r_ext, g_ext, b_ext, d_ext;
   logic                   hit_r, hit_g, hit_b;

   assign last_pixel = (count + 23'd1) == image_size;
   assign pipe_empty = !cap_valid && !s1_valid && !write_image;
   assign busy       = (state != IDLE) && (state != WAIT_SOF);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      inject     = 1'b0;
      start      = 1'b0;
      set_short  = 1'b0;
      frame_end  = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && image_size != 23'd0) next_state = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (in_sof && in_valid) begin
               accept     = 1'b1;
               start      = 1'b1;
               next_state = (image_size == 23'd1) ? FLUSH : STREAM;
            end else if (!enable) begin
               next_state = IDLE;
            end
         end
         STREAM: begin
            if (in_valid) begin
               if (in_sof) begin
                  // A premature SOF is dropped; the frame is padded out with class 0.
                  set_short  = 1'b1;
                  next_state = PAD;
               end else begin
                  accept = 1'b1;
                  if (last_pixel) next_state = FLUSH;
               end
            end
         end
         PAD: begin
            inject = 1'b1;
            if (last_pixel) next_state = FLUSH;
         end
         FLUSH: begin
            if (pipe_empty && write_image_done) begin
               frame_end  = 1'b1;
               next_state = enable ? WAIT_SOF : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count          <= '0;
         write_image_en <= 1'b0;
         frames_done    <= '0;
         short_frame    <= 1'b0;
      end else begin
         if (frame_end)              count <= '0;
         else if (accept || inject)  count <= count + 23'd1;

         if (start)          write_image_en <= 1'b1;
         else if (frame_end) write_image_en <= 1'b0;

         if (frame_end) frames_done <= frames_done + 16'd1;

         if (set_short)         short_frame <= 1'b1;
         else if (clear_status) short_frame <= 1'b0;
      end
   end

   // Sums are formed one bit wider so o + diff_thr can never wrap.
   assign r_ext = {1'b0, cap_red};
   assign g_ext = {1'b0, cap_green};
   assign b_ext = {1'b0, cap_blue};
   assign d_ext = {1'b0, diff_thr};

   assign hit_r = (cap_red   >= red_thr)   && (r_ext > g_ext + d_ext) && (r_ext > b_ext + d_ext);
   assign hit_g = (cap_green >= green_thr) && (g_ext > r_ext + d_ext) && (g_ext > b_ext + d_ext);
   assign hit_b = (cap_blue  >= blue_thr)  && (b_ext > r_ext + d_ext) && (b_ext > g_ext + d_ext);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cap_valid        <= 1'b0;
         cap_pad          <= 1'b0;
         cap_red          <= '0;
         cap_green        <= '0;
         cap_blue         <= '0;
         s1_valid         <= 1'b0;
         s1_hit           <= '0;
         write_image      <= 1'b0;
         write_image_data <= '0;
      end else begin
         cap_valid <= accept || inject;
         if (accept || inject) begin
            cap_pad   <= inject;
            cap_red   <= in_red;
            cap_green <= in_green;
            cap_blue  <= in_blue;
         end

         s1_valid <= cap_valid;
         s1_hit   <= cap_pad ? 3'b000 : {hit_b, hit_g, hit_r};

         write_image <= s1_valid;
         if (s1_valid) begin
            unique case (1'b1)
               s1_hit[0]: write_image_data <= 2'd1;
               s1_hit[1]: write_image_data <= 2'd2;
               s1_hit[2]: write_image_data <= 2'd3;
               default:   write_image_data <= 2'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_classifier.sv
// Directed bench for pixel_classifier: a queue of expected classes is filled as
// pixels are driven and drained by a monitor that compares each write strobe.
module tb_pixel_classifier;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [22:0] image_size = 23'd64;
   logic [7:0]  red_thr = 8'd100, green_thr = 8'd100, blue_thr = 8'd100, diff_thr = 8'd20;
   logic        in_sof = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_red = '0, in_green = '0, in_blue = '0;
   logic        write_image_en, write_image, write_image_done = 1'b0;
   logic [1:0]  write_image_data;
   logic        clear_status = 1'b0;
   logic        short_frame, busy;
   logic [15:0] frames_done;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          strobes = 0;
   int          sof_cyc = 0;
   int          first_cyc = -1;
   bit          first_pending = 1'b0;
   logic [1:0]  exp_q[$];

   pixel_classifier dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .image_size(image_size),
      .red_thr(red_thr), .green_thr(green_thr), .blue_thr(blue_thr), .diff_thr(diff_thr),
      .in_sof(in_sof), .in_valid(in_valid), .in_red(in_red), .in_green(in_green),
      .in_blue(in_blue), .write_image_en(write_image_en), .write_image(write_image),
      .write_image_data(write_image_data), .write_image_done(write_image_done),
      .clear_status(clear_status), .short_frame(short_frame), .busy(busy),
      .frames_done(frames_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vec++;
      assert (observed === expected)
      else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] classify(input int r, input int g, input int b);
      int d;
      d = int'(diff_thr);
      if (r >= int'(red_thr) && r > g + d && r > b + d)   return 2'd1;
      if (g >= int'(green_thr) && g > r + d && g > b + d) return 2'd2;
      if (b >= int'(blue_thr) && b > r + d && b > g + d)  return 2'd3;
      return 2'd0;
   endfunction

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && write_image) begin
         strobes++;
         if (first_pending) begin
            first_cyc     = cyc;
            first_pending = 1'b0;
         end
         if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
         else                   check("class", 32'(write_image_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic send(input logic sof, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit push);
      @(negedge clock);
      in_valid = 1'b1;
      in_sof   = sof;
      in_red   = r;
      in_green = g;
      in_blue  = b;
      if (sof) sof_cyc = cyc + 1;
      if (push) exp_q.push_back(classify(r, g, b));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         in_valid = 1'b0;
         in_sof   = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || write_image) && k < 300) begin
         @(negedge clock);
         k++;
      end
      if (k >= 300) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic finish_frame(input logic [15:0] exp_frames, input int exp_strobes);
      idle(1);
      wait_drain();
      check("strobe_count", 32'(strobes), 32'(exp_strobes));
      check("en_before_done", 32'(write_image_en), 32'd1);
      @(negedge clock);
      write_image_done = 1'b1;
      @(negedge clock);
      write_image_done = 1'b0;
      check("en_after_done", 32'(write_image_en), 32'd0);
      check("frames_done", 32'(frames_done), 32'(exp_frames));
      strobes = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   typedef struct packed { logic [7:0] r, g, b; } rgb_t;
   rgb_t tbl[8];

   initial begin
      tbl[0] = '{8'd200, 8'd10, 8'd10};
      tbl[1] = '{8'd140, 8'd150, 8'd0};
      tbl[2] = '{8'd140, 8'd170, 8'd0};
      tbl[3] = '{8'd10, 8'd10, 8'd200};
      tbl[4] = '{8'd100, 8'd0, 8'd0};
      tbl[5] = '{8'd99, 8'd0, 8'd0};
      tbl[6] = '{8'd150, 8'd130, 8'd0};
      tbl[7] = '{8'd255, 8'd250, 8'd0};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_en", 32'(write_image_en), 32'd0);
      check("rst_strobe", 32'(write_image), 32'd0);
      check("rst_data", 32'(write_image_data), 32'd0);
      check("rst_short", 32'(short_frame), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frames", 32'(frames_done), 32'd0);
      reset_n = 1'b1;

      // Full red frame, first-strobe latency, done ignored outside FLUSH
      enable = 1'b1;
      idle(2);
      check("wait_sof_busy", 32'(busy), 32'd0);
      first_pending = 1'b1;
      for (int i = 0; i < 64; i++) begin
         send(i == 0, 8'd200, 8'd10, 8'd10, 1'b1);
         write_image_done = (i == 30);
         if (i == 2) check("stream_en", 32'(write_image_en), 32'd1);
         if (i == 2) check("stream_busy", 32'(busy), 32'd1);
      end
      write_image_done = 1'b0;
      finish_frame(16'd1, 64);
      check("first_latency", 32'(first_cyc - sof_cyc), 32'd2);
      check("rearm_busy", 32'(busy), 32'd0);

      // Classification boundaries
      for (int i = 0; i < 64; i++) begin
         send(i == 0, tbl[i % 8].r, tbl[i % 8].g, tbl[i % 8].b, 1'b1);
      end
      finish_frame(16'd2, 64);

      // Short frame: SOF after 40 pixels, 24 padded zeros, next frame skipped
      for (int i = 0; i < 40; i++) send(i == 0, 8'd200, 8'd10, 8'd10, 1'b1);
      send(1'b1, 8'd200, 8'd10, 8'd10, 1'b0);
      for (int i = 0; i < 24; i++) exp_q.push_back(2'd0);
      idle(1);
      check("short_set", 32'(short_frame), 32'd1);
      check("pad_busy", 32'(busy), 32'd1);
      finish_frame(16'd3, 64);
      for (int i = 0; i < 10; i++) send(1'b0, 8'd200, 8'd10, 8'd10, 1'b0);
      idle(4);
      check("skipped_en", 32'(write_image_en), 32'd0);
      check("skipped_strobes", 32'(strobes), 32'd0);
      @(negedge clock);
      clear_status = 1'b1;
      @(negedge clock);
      clear_status = 1'b0;
      check("short_cleared", 32'(short_frame), 32'd0);

      // Overlong frame: 70 pixels, only 64 strobes
      for (int i = 0; i < 70; i++) send(i == 0, 8'd10, 8'd10, 8'd200, i < 64);
      finish_frame(16'd4, 64);

      // enable dropped mid-frame: frame completes, then IDLE
      for (int i = 0; i < 64; i++) begin
         send(i == 0, 8'd10, 8'd170, 8'd20, 1'b1);
         if (i == 9) enable = 1'b0;
      end
      finish_frame(16'd5, 64);
      idle(2);
      check("disabled_busy", 32'(busy), 32'd0);
      check("disabled_en", 32'(write_image_en), 32'd0);

      // image_size = 0 never starts
      image_size = 23'd0;
      enable     = 1'b1;
      idle(3);
      send(1'b1, 8'd200, 8'd10, 8'd10, 1'b0);
      idle(4);
      check("size0_en", 32'(write_image_en), 32'd0);
      check("size0_strobes", 32'(strobes), 32'd0);

      // Asynchronous reset during STREAM
      image_size = 23'd64;
      idle(2);
      for (int i = 0; i < 20; i++) send(i == 0, 8'd200, 8'd10, 8'd10, 1'b1);
      idle(1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("areset_en", 32'(write_image_en), 32'd0);
      check("areset_strobe", 32'(write_image), 32'd0);
      check("areset_data", 32'(write_image_data), 32'd0);
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_frames", 32'(frames_done), 32'd0);
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      strobes = 0;
      idle(2);
      for (int i = 0; i < 5; i++) send(1'b0, 8'd200, 8'd10, 8'd10, 1'b0);
      idle(4);
      check("post_reset_en", 32'(write_image_en), 32'd0);
      check("post_reset_strobes", 32'(strobes), 32'd0);

      // Restart with a new SOF on a 4-pixel frame
      image_size = 23'd4;
      for (int i = 0; i < 4; i++) send(i == 0, tbl[i].r, tbl[i].g, tbl[i].b, 1'b1);
      finish_frame(16'd1, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
